// File: rtl/ttt_pkg.sv
// Shared types and the win-line table for the tic-tac-toe controller.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } cell_t;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef cell_t [NUM_CELLS-1:0] board_t;

  // Zero-based cell indices, row-major from the top-left corner.
  localparam int unsigned WIN_LINES [NUM_LINES][3] = '{
    '{0, 1, 2},
    '{3, 4, 5},
    '{6, 7, 8},
    '{0, 3, 6},
    '{1, 4, 7},
    '{2, 5, 8},
    '{0, 4, 8},
    '{2, 4, 6}
  };

endpackage

// File: rtl/ttt_line_check.sv
// Reports whether one player owns any line and which cells sit on those lines.
module ttt_line_check
  import ttt_pkg::*;
(
  input  board_t                board,
  input  cell_t                 player,
  output logic                  owns,
  output logic [NUM_CELLS-1:0]  mask
);

  always_comb begin
    owns = 1'b0;
    mask = '0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (board[WIN_LINES[l][0]] == player &&
          board[WIN_LINES[l][1]] == player &&
          board[WIN_LINES[l][2]] == player) begin
        owns = 1'b1;
        mask[WIN_LINES[l][0]] = 1'b1;
        mask[WIN_LINES[l][1]] = 1'b1;
        mask[WIN_LINES[l][2]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tic_tac_toe_game.sv
// Two-player tic-tac-toe controller: edge-detected cell requests,
// move legality, board/turn state and win/draw decode.
module tic_tac_toe_game
  import ttt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk1,
  input  logic clk2,
  input  logic clk3,
  input  logic clk4,
  input  logic clk5,
  input  logic clk6,
  input  logic clk7,
  input  logic clk8,
  input  logic clk9,
  output logic winP1,
  output logic winP2,
  output logic draw,
  output logic i1p1,
  output logic i2p1,
  output logic i3p1,
  output logic i4p1,
  output logic i5p1,
  output logic i6p1,
  output logic i7p1,
  output logic i8p1,
  output logic i9p1,
  output logic i1p2,
  output logic i2p2,
  output logic i3p2,
  output logic i4p2,
  output logic i5p2,
  output logic i6p2,
  output logic i7p2,
  output logic i8p2,
  output logic i9p2,
  output logic xI1,
  output logic xI2,
  output logic xI3,
  output logic xI4,
  output logic xI5,
  output logic xI6,
  output logic xI7,
  output logic xI8,
  output logic xI9
);

  board_t                board;
  logic                  turn;
  logic [NUM_CELLS-1:0]  prev;
  logic [NUM_CELLS-1:0]  btn;
  logic [NUM_CELLS-1:0]  req;
  logic [NUM_CELLS-1:0]  own1;
  logic [NUM_CELLS-1:0]  own2;
  logic [NUM_CELLS-1:0]  mask1;
  logic [NUM_CELLS-1:0]  mask2;
  logic [NUM_CELLS-1:0]  xi;
  logic                  win1;
  logic                  win2;
  logic                  full;
  logic                  over;
  logic                  target_empty;
  logic                  accept;

  assign btn = {clk9, clk8, clk7, clk6, clk5,
                clk4, clk3, clk2, clk1};
  assign req = btn & ~prev;

  ttt_line_check u_check_p1 (
    .board  (board),
    .player (P1),
    .owns   (win1),
    .mask   (mask1)
  );

  ttt_line_check u_check_p2 (
    .board  (board),
    .player (P2),
    .owns   (win2),
    .mask   (mask2)
  );

  always_comb begin
    own1 = '0;
    own2 = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      own1[i] = (board[i] == P1);
      own2[i] = (board[i] == P2);
    end
  end

  assign full = &(own1 | own2);
  assign over = win1 | win2 | draw;

  // Only meaningful when req is one-hot; gated by $onehot below.
  always_comb begin
    target_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (req[i] && board[i] == EMPTY) begin
        target_empty = 1'b1;
      end
    end
  end

  assign accept = $onehot(req) & target_empty & ~over;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
      turn <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        board[i] <= EMPTY;
      end
    end else begin
      prev <= btn;
      if (accept) begin
        turn <= ~turn;
        for (int i = 0; i < NUM_CELLS; i++) begin
          if (req[i]) begin
            board[i] <= turn ? P2 : P1;
          end
        end
      end
    end
  end

  assign winP1 = win1;
  assign winP2 = win2;
  assign draw  = full & ~win1 & ~win2;

  assign xi = ({NUM_CELLS{win1}} & mask1) |
              ({NUM_CELLS{win2}} & mask2);

  assign i1p1 = own1[0];
  assign i2p1 = own1[1];
  assign i3p1 = own1[2];
  assign i4p1 = own1[3];
  assign i5p1 = own1[4];
  assign i6p1 = own1[5];
  assign i7p1 = own1[6];
  assign i8p1 = own1[7];
  assign i9p1 = own1[8];

  assign i1p2 = own2[0];
  assign i2p2 = own2[1];
  assign i3p2 = own2[2];
  assign i4p2 = own2[3];
  assign i5p2 = own2[4];
  assign i6p2 = own2[5];
  assign i7p2 = own2[6];
  assign i8p2 = own2[7];
  assign i9p2 = own2[8];

  assign xI1 = xi[0];
  assign xI2 = xi[1];
  assign xI3 = xi[2];
  assign xI4 = xi[3];
  assign xI5 = xi[4];
  assign xI6 = xi[5];
  assign xI7 = xi[6];
  assign xI8 = xi[7];
  assign xI9 = xi[8];

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Directed self-checking bench for tic_tac_toe_game.
module tb_tic_tac_toe_game;

  logic       clk;
  logic       reset;
  logic [8:0] btn;
  logic       winP1, winP2, draw;
  logic i1p1, i2p1, i3p1, i4p1, i5p1, i6p1, i7p1, i8p1, i9p1;
  logic i1p2, i2p2, i3p2, i4p2, i5p2, i6p2, i7p2, i8p2, i9p2;
  logic xI1, xI2, xI3, xI4, xI5, xI6, xI7, xI8, xI9;
  logic [8:0] p1, p2, xi;
  int         n_cmp;
  int         n_bad;

  assign p1 = {i9p1, i8p1, i7p1, i6p1, i5p1, i4p1, i3p1, i2p1, i1p1};
  assign p2 = {i9p2, i8p2, i7p2, i6p2, i5p2, i4p2, i3p2, i2p2, i1p2};
  assign xi = {xI9, xI8, xI7, xI6, xI5, xI4, xI3, xI2, xI1};

  tic_tac_toe_game dut (
    .clk   (clk),
    .reset (reset),
    .clk1  (btn[0]),
    .clk2  (btn[1]),
    .clk3  (btn[2]),
    .clk4  (btn[3]),
    .clk5  (btn[4]),
    .clk6  (btn[5]),
    .clk7  (btn[6]),
    .clk8  (btn[7]),
    .clk9  (btn[8]),
    .winP1 (winP1),
    .winP2 (winP2),
    .draw  (draw),
    .i1p1  (i1p1),
    .i2p1  (i2p1),
    .i3p1  (i3p1),
    .i4p1  (i4p1),
    .i5p1  (i5p1),
    .i6p1  (i6p1),
    .i7p1  (i7p1),
    .i8p1  (i8p1),
    .i9p1  (i9p1),
    .i1p2  (i1p2),
    .i2p2  (i2p2),
    .i3p2  (i3p2),
    .i4p2  (i4p2),
    .i5p2  (i5p2),
    .i6p2  (i6p2),
    .i7p2  (i7p2),
    .i8p2  (i8p2),
    .i9p2  (i9p2),
    .xI1   (xI1),
    .xI2   (xI2),
    .xI3   (xI3),
    .xI4   (xI4),
    .xI5   (xI5),
    .xI6   (xI6),
    .xI7   (xI7),
    .xI8   (xI8),
    .xI9   (xI9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One press: rise sampled at the next posedge, released a cycle later.
  task automatic move(input int n);
    @(negedge clk);
    btn[n-1] = 1'b1;
    @(negedge clk);
    btn[n-1] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({p1, p2, xi} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_cells: got %h want 0", {p1, p2, xi});
    end
    n_cmp++;
    if ({winP1, winP2, draw} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000", {winP1, winP2, draw});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({p1, p2, xi, winP1, winP2, draw} !== 30'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %h want 0",
               {p1, p2, xi, winP1, winP2, draw});
    end
  endtask

  task automatic test_win_p1();
    do_reset();
    move(1);
    move(5);
    move(2);
    move(1);
    n_cmp++;
    if (p1 !== 9'b000000011 || p2 !== 9'b000010000) begin
      n_bad++;
      $display("FAIL occupied_repeat: got p1=%b p2=%b want p1=000000011 p2=000010000",
               p1, p2);
    end
    move(7);
    n_cmp++;
    if (p2 !== 9'b001010000) begin
      n_bad++;
      $display("FAIL turn_after_repeat: got p2=%b want 001010000", p2);
    end
    move(3);
    n_cmp++;
    if ({winP1, winP2, draw} !== 3'b100) begin
      n_bad++;
      $display("FAIL p1_row_win: got %b want 100", {winP1, winP2, draw});
    end
    n_cmp++;
    if (xi !== 9'b000000111) begin
      n_bad++;
      $display("FAIL p1_row_xi: got %b want 000000111", xi);
    end
    move(6);
    n_cmp++;
    if (i6p1 !== 1'b0 || i6p2 !== 1'b0 ||
        p1 !== 9'b000000111 || p2 !== 9'b001010000) begin
      n_bad++;
      $display("FAIL move_after_win: got p1=%b p2=%b want p1=000000111 p2=001010000",
               p1, p2);
    end
  endtask

  task automatic test_draw();
    int seq [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    do_reset();
    for (int i = 0; i < 8; i++) move(seq[i]);
    n_cmp++;
    if (draw !== 1'b0) begin
      n_bad++;
      $display("FAIL draw_early: got %b want 0", draw);
    end
    move(seq[8]);
    n_cmp++;
    if (p1 !== 9'b110001101 || p2 !== 9'b001110010) begin
      n_bad++;
      $display("FAIL draw_board: got p1=%b p2=%b want p1=110001101 p2=001110010",
               p1, p2);
    end
    n_cmp++;
    if ({winP1, winP2, draw} !== 3'b001 || xi !== 9'd0) begin
      n_bad++;
      $display("FAIL draw_flags: got flags=%b xi=%b want 001 xi=0",
               {winP1, winP2, draw}, xi);
    end
  endtask

  task automatic test_win_p2();
    int seq [6] = '{1, 3, 4, 6, 8, 9};
    do_reset();
    foreach (seq[i]) move(seq[i]);
    n_cmp++;
    if ({winP1, winP2, draw} !== 3'b010) begin
      n_bad++;
      $display("FAIL p2_col_win: got %b want 010", {winP1, winP2, draw});
    end
    n_cmp++;
    if (xi !== 9'b100100100) begin
      n_bad++;
      $display("FAIL p2_col_xi: got %b want 100100100", xi);
    end
  endtask

  task automatic test_multi_and_hold();
    do_reset();
    @(negedge clk);
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    n_cmp++;
    if (p1 !== 9'd0 || p2 !== 9'd0) begin
      n_bad++;
      $display("FAIL double_request: got p1=%b p2=%b want 0", p1, p2);
    end
    btn[4] = 1'b1;
    repeat (10) @(negedge clk);
    btn[4] = 1'b0;
    n_cmp++;
    if (p1 !== 9'b000010000 || p2 !== 9'd0) begin
      n_bad++;
      $display("FAIL held_request: got p1=%b p2=%b want p1=000010000 p2=0",
               p1, p2);
    end
    move(1);
    n_cmp++;
    if (p2 !== 9'b000000001) begin
      n_bad++;
      $display("FAIL turn_after_hold: got p2=%b want 000000001", p2);
    end
  endtask

  task automatic test_reset_mid_game();
    do_reset();
    move(1);
    move(2);
    move(3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({p1, p2, xi, winP1, winP2, draw} !== 30'd0) begin
      n_bad++;
      $display("FAIL async_clear: got %h want 0",
               {p1, p2, xi, winP1, winP2, draw});
    end
    btn[6] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (p1 !== 9'd0) begin
      n_bad++;
      $display("FAIL press_in_reset: got p1=%b want 0", p1);
    end
    reset = 1'b0;
    @(negedge clk);
    btn[6] = 1'b0;
    n_cmp++;
    if (p1 !== 9'b001000000 || p2 !== 9'd0) begin
      n_bad++;
      $display("FAIL held_through_reset: got p1=%b p2=%b want p1=001000000 p2=0",
               p1, p2);
    end
    move(9);
    n_cmp++;
    if (p2 !== 9'b100000000) begin
      n_bad++;
      $display("FAIL move_after_reset: got p2=%b want 100000000", p2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    btn = '0;
    test_reset();
    test_win_p1();
    test_draw();
    test_win_p2();
    test_multi_and_hold();
    test_reset_mid_game();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
